alu_result_stage: RTL and testbench

- Writeback stage directly downstream of the ALU. Consumes the 64-bit ALU result and buffers it in a small FIFO.
- Serialises the result onto the 32-bit writeback path: one word for single-word ops, LO then HI for MUL/DIV.
- Updates condition flags on every accepted result.
- Decouples ALU issue from register-file/bus availability via valid/ready handshakes.

---
 rtl/alu_result_stage_if.sv | 27 ++
 rtl/alu_result_stage.sv | 179 +++++++++++++++++
 tb/tb_alu_result_stage.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// ALU result stage handshake bundle.
// Upstream side:   in_valid/in_ready handshake carrying in_opcode, in_result, in_dest.
// Downstream side: out_valid/out_ready handshake carrying out_data, out_sel, out_dest.
// slave  : view taken by alu_result_stage (consumes in_*, produces out_*).
// master : view taken by the surrounding environment (produces in_*, consumes out_*).
interface alu_result_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opcode;
  logic [63:0] in_result;
  logic [3:0]  in_dest;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
  logic [3:0]  out_dest;

  modport slave (
    input  in_valid, in_opcode, in_result, in_dest, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_dest
  );

  modport master (
    output in_valid, in_opcode, in_result, in_dest, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_dest
  );
endinterface

// File: rtl/alu_result_stage.sv
// ALU writeback stage: buffers 64-bit ALU results in a DEPTH-entry FIFO and
// serialises them onto a 32-bit writeback path (one word for single-word ops,
// LO then HI for MUL/DIV). Condition flags update on every accepted result.
// Ports:
//   clk        rising-edge clock
//   clr        synchronous active-high reset (drops all buffered/in-flight words)
//   bus        alu_result_stage_if.slave: in_* handshake from ALU, out_* to writeback
//   flag_zero  last accepted result was zero
//   flag_neg   last accepted result was negative
//   busy       FIFO non-empty
// Optional feature: define ALU_RESULT_BYPASS_EN to let single-word results pass
// straight from in_* to out_* when the stage is idle (zero-latency writeback).
module alu_result_stage #(
  parameter int unsigned DEPTH  = 2,
  parameter logic [4:0]  OP_MUL = 5'b01111,
  parameter logic [4:0]  OP_DIV = 5'b10000
) (
  input  logic                  clk,
  input  logic                  clr,
  alu_result_stage_if.slave     bus,
  output logic                  flag_zero,
  output logic                  flag_neg,
  output logic                  busy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic        two_word;
    logic [63:0] result;
    logic [3:0]  dest;
  } entry_t;

  typedef enum logic {
    ST_LO = 1'b0,
    ST_HI = 1'b1
  } state_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  state_t           state;
  state_t           state_nxt;

  entry_t head;
  logic   empty;
  logic   full;
  logic   in_two_word;
  logic   accept;
  logic   push;
  logic   pop;
  logic   bypass;

  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
  logic [3:0]  out_dest;

  assign head        = mem[rd_ptr];
  assign empty       = (count == '0);
  assign full        = (count == CNT_W'(DEPTH));
  assign in_two_word = (bus.in_opcode == OP_MUL) || (bus.in_opcode == OP_DIV);
  assign accept      = bus.in_valid && !full;

`ifdef ALU_RESULT_BYPASS_EN
  // Idle stage and single-word op: present the incoming word directly.
  assign bypass = empty && (state == ST_LO) && bus.in_valid && !in_two_word;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word taken downstream this cycle never enters the FIFO.
  assign push = accept && !(bypass && bus.out_ready);

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_LO;
    end else begin
      state <= state_nxt;
    end
  end

  // Drain FSM next-state, pop decision and output mux.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_sel   = 2'b00;
    out_dest  = '0;
    case (state)
      ST_LO: begin
        out_valid = !empty;
        out_data  = head.result[31:0];
        out_sel   = head.two_word ? 2'b01 : 2'b00;
        out_dest  = head.dest;
        if (!empty && bus.out_ready) begin
          if (head.two_word) begin
            state_nxt = ST_HI;
          end else begin
            pop = 1'b1;
          end
        end
        if (bypass) begin
          out_valid = 1'b1;
          out_data  = bus.in_result[31:0];
          out_sel   = 2'b00;
          out_dest  = bus.in_dest;
        end
      end
      ST_HI: begin
        out_valid = !empty;
        out_data  = head.result[63:32];
        out_sel   = 2'b10;
        out_dest  = head.dest;
        if (bus.out_ready) begin
          pop       = 1'b1;
          state_nxt = ST_LO;
        end
      end
      default: state_nxt = ST_LO;
    endcase
  end

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr] <= '{two_word: in_two_word, result: bus.in_result, dest: bus.in_dest};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two DEPTH.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Condition flags track every accepted result, bypassed or buffered.
  always_ff @(posedge clk) begin
    if (clr) begin
      flag_zero <= 1'b0;
      flag_neg  <= 1'b0;
    end else if (accept) begin
      if (in_two_word) begin
        flag_zero <= (bus.in_result == 64'd0);
        flag_neg  <= bus.in_result[63];
      end else begin
        flag_zero <= (bus.in_result[31:0] == 32'd0);
        flag_neg  <= bus.in_result[31];
      end
    end
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_sel   = out_sel;
  assign bus.out_dest  = out_dest;
  assign busy          = !empty;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
module tb_alu_result_stage;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;

  logic clk;
  logic clr;
  logic flag_zero;
  logic flag_neg;
  logic busy;

  int checks = 0;
  int errors = 0;

  alu_result_stage_if bus ();

  alu_result_stage #(
    .DEPTH  (2),
    .OP_MUL (OP_MUL),
    .OP_DIV (OP_DIV)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .bus       (bus),
    .flag_zero (flag_zero),
    .flag_neg  (flag_neg),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [63:0] res,
                       input logic [3:0] dest);
    bus.in_valid  = v;
    bus.in_opcode = op;
    bus.in_result = res;
    bus.in_dest   = dest;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] data, input logic [1:0] sel);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_data"},  64'(bus.out_data),  64'(data));
    chk({tag, "_sel"},   64'(bus.out_sel),   64'(sel));
  endtask

  initial begin
    clr = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b0, OP_ADD, 64'd0, 4'd0);
    tick();
    tick();
    clr = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_busy",      64'(busy),          64'd0);
    chk("rst_zero",      64'(flag_zero),     64'd0);
    chk("rst_neg",       64'(flag_neg),      64'd0);

    // ADD 15 -> dest 3
    bus.out_ready = 1'b1;
    drive(1'b1, OP_ADD, 64'd15, 4'd3);
    #1;
`ifdef ALU_RESULT_BYPASS_EN
    chk_word("add15_byp", 32'd15, 2'b00);
    chk("add15_dest", 64'(bus.out_dest), 64'd3);
    tick();
    drive(1'b0, OP_ADD, 64'd0, 4'd0);
    #1;
    chk("add15_byp_empty", 64'(bus.out_valid), 64'd0);
    chk("add15_byp_busy",  64'(busy),          64'd0);
`else
    chk("add15_no_comb", 64'(bus.out_valid), 64'd0);
    tick();
    drive(1'b0, OP_ADD, 64'd0, 4'd0);
    #1;
    chk_word("add15", 32'd15, 2'b00);
    chk("add15_dest", 64'(bus.out_dest), 64'd3);
    chk("add15_busy", 64'(busy),         64'd1);
    tick();
    chk("add15_drained", 64'(bus.out_valid), 64'd0);
`endif
    chk("add15_zero", 64'(flag_zero), 64'd0);
    chk("add15_neg",  64'(flag_neg),  64'd0);

    // MUL 723*19
    drive(1'b1, OP_MUL, 64'h0000_0000_0000_35A9, 4'd1);
    tick();
    drive(1'b0, OP_ADD, 64'd0, 4'd0);
    #1;
    chk_word("mul_pos_lo", 32'h0000_35A9, 2'b01);
    chk("mul_pos_neg",  64'(flag_neg),  64'd0);
    chk("mul_pos_zero", 64'(flag_zero), 64'd0);
    tick();
    chk_word("mul_pos_hi", 32'h0000_0000, 2'b10);
    tick();
    chk("mul_pos_done", 64'(bus.out_valid), 64'd0);

    // MUL -723*19
    drive(1'b1, OP_MUL, 64'hFFFF_FFFF_FFFF_CA57, 4'd2);
    tick();
    drive(1'b0, OP_ADD, 64'd0, 4'd0);
    #1;
    chk_word("mul_neg_lo", 32'hFFFF_CA57, 2'b01);
    chk("mul_neg_neg",  64'(flag_neg),  64'd1);
    chk("mul_neg_zero", 64'(flag_zero), 64'd0);
    tick();
    chk_word("mul_neg_hi", 32'hFFFF_FFFF, 2'b10);
    tick();
    chk("mul_neg_done", 64'(busy), 64'd0);

    // DIV 780/40 -> quotient 19 (LO), remainder 20 (HI)
    drive(1'b1, OP_DIV, {32'd20, 32'd19}, 4'd4);
    tick();
    drive(1'b0, OP_ADD, 64'd0, 4'd0);
    #1;
    chk_word("div_lo", 32'd19, 2'b01);
    chk("div_neg", 64'(flag_neg), 64'd0);
    tick();
    chk_word("div_hi", 32'd20, 2'b10);
    tick();
    chk("div_done", 64'(bus.out_valid), 64'd0);

    // SUB with zero result, held back by out_ready=0 so both builds buffer it
    bus.out_ready = 1'b0;
    drive(1'b1, OP_SUB, 64'd0, 4'd6);
    tick();
    drive(1'b0, OP_ADD, 64'd0, 4'd0);
    #1;
    chk("sub_zero",     64'(flag_zero), 64'd1);
    chk("sub_neg",      64'(flag_neg),  64'd0);
    chk_word("sub_word", 32'd0, 2'b00);
    chk("sub_dest", 64'(bus.out_dest), 64'd6);
    bus.out_ready = 1'b1;
    tick();
    chk("sub_done", 64'(bus.out_valid), 64'd0);

    // Backpressure: fill FIFO, hold a third request, then drain in order
    bus.out_ready = 1'b0;
    drive(1'b1, OP_ADD, 64'd5, 4'd1);
    tick();
    chk("bp_zero_clear", 64'(flag_zero), 64'd0);
    drive(1'b1, OP_ADD, 64'd6, 4'd2);
    tick();
    drive(1'b1, OP_ADD, 64'd9, 4'd4);
    #1;
    chk("bp_full_ready", 64'(bus.in_ready), 64'd0);
    chk_word("bp_head5", 32'd5, 2'b00);
    tick();
    chk("bp_still_full", 64'(bus.in_ready), 64'd0);
    chk_word("bp_stable5", 32'd5, 2'b00);
    chk("bp_stable_dest", 64'(bus.out_dest), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    chk_word("bp_word6", 32'd6, 2'b00);
    chk("bp_ready_again", 64'(bus.in_ready), 64'd1);
    tick();
    drive(1'b0, OP_ADD, 64'd0, 4'd0);
    #1;
    chk_word("bp_word9", 32'd9, 2'b00);
    chk("bp_dest9", 64'(bus.out_dest), 64'd4);
    tick();
    chk("bp_done", 64'(bus.out_valid), 64'd0);

    // Reset after the MUL LO beat has been taken
    drive(1'b1, OP_MUL, 64'hFFFF_FFFF_FFFF_CA57, 4'd7);
    tick();
    drive(1'b0, OP_ADD, 64'd0, 4'd0);
    #1;
    chk_word("rm_lo", 32'hFFFF_CA57, 2'b01);
    tick();
    chk_word("rm_hi_pending", 32'hFFFF_FFFF, 2'b10);
    clr = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    clr = 1'b0;
    #1;
    chk("rm_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rm_busy",      64'(busy),          64'd0);
    chk("rm_zero",      64'(flag_zero),     64'd0);
    chk("rm_neg",       64'(flag_neg),      64'd0);
    chk("rm_in_ready",  64'(bus.in_ready),  64'd1);
    drive(1'b1, OP_ADD, 64'd7, 4'd5);
    tick();
    drive(1'b0, OP_ADD, 64'd0, 4'd0);
    #1;
    chk_word("rm_add7", 32'd7, 2'b00);
    chk("rm_add7_dest", 64'(bus.out_dest), 64'd5);
    bus.out_ready = 1'b1;
    tick();
    chk("rm_final_empty", 64'(bus.out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
